// File: rtl/cstn_pkg.sv
// Panel geometry shared with the CSTN timing generator, plus the fetch FSM state type.
package cstn_pkg;

  localparam int unsigned LINE_WORDS = 240;
  localparam int unsigned V_HALF     = 240;
  localparam int unsigned FB_WORDS   = 2 * V_HALF * LINE_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_U = 2'd1,
    ST_FETCH_L = 2'd2,
    ST_DRAIN   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/cstn_fetch_addr_gen.sv
// Framebuffer read addressing for one dual-scan line (upper row, then lower row)
// and the one-cycle delayed line-buffer write strobe/address pipeline.
module cstn_fetch_addr_gen
  import cstn_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned LB_AW  = 8,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              issue,
  input  logic              bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last_word_c,
  output logic              lb_we,
  output logic              lb_bank,
  output logic              lb_half,
  output logic [LB_AW-1:0]  lb_addr
);

  localparam int unsigned HALF_OFS = V_HALF * LINE_WORDS;

  logic [ADDR_W-1:0] base;
  logic [LB_AW-1:0]  word;
  logic              half;

  assign last_word_c = (word == LB_AW'(LINE_WORDS - 1));

  // Row base is a registered constant multiply taken once per line, off the issue path.
  always_ff @(posedge clk) begin
    if (reset) begin
      base    <= '0;
      rd_addr <= '0;
      word    <= '0;
      half    <= 1'b0;
      lb_we   <= 1'b0;
      lb_bank <= 1'b0;
      lb_half <= 1'b0;
      lb_addr <= '0;
    end else begin
      lb_we <= issue;
      if (issue) begin
        lb_bank <= bank;
        lb_half <= half;
        lb_addr <= word;
      end

      if (load) begin
        base    <= ADDR_W'(load_idx) * ADDR_W'(LINE_WORDS);
        rd_addr <= ADDR_W'(load_idx) * ADDR_W'(LINE_WORDS);
        word    <= '0;
        half    <= 1'b0;
      end else if (issue) begin
        if (last_word_c) begin
          word <= '0;
          if (!half) begin
            half    <= 1'b1;
            rd_addr <= base + ADDR_W'(HALF_OFS);
          end
        end else begin
          word    <= word + LB_AW'(1);
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cstn_fetch_arbiter.sv
// Single-port framebuffer arbiter: display line fetch into a ping-pong line buffer
// with priority, host pixel writes in guaranteed slots and whenever no fetch runs.
module cstn_fetch_arbiter
  import cstn_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned LB_AW      = 8,
  parameter int unsigned HOST_SHARE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [7:0]        line_idx,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic              lb_half,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              disp_bank,
  output logic              line_ready,
  output logic              underrun
);

  localparam int unsigned SLOT_W = (HOST_SHARE > 1) ? $clog2(HOST_SHARE) : 1;
  localparam logic [SLOT_W-1:0] SLOT_HOST = SLOT_W'(HOST_SHARE - 1);

  fetch_state_e      state;
  logic              fetch_bank;
  logic [SLOT_W-1:0] slot;
  logic [ADDR_W-1:0] rd_addr;
  logic              last_word_c;

  logic fetching_c;
  logic host_slot_c;
  logic start_ok_c;
  logic in_range_c;
  logic grant_c;
  logic host_wr_c;
  logic issue_c;

  // Slot arbitration: an unclaimed host slot falls back to the fetch.
  always_comb begin
    fetching_c  = (state == ST_FETCH_U) || (state == ST_FETCH_L);
    host_slot_c = !fetching_c || (slot == SLOT_HOST);
    start_ok_c  = line_start && (32'(line_idx) < V_HALF);
    in_range_c  = (wr_addr < ADDR_W'(FB_WORDS));
    grant_c     = !reset && wr_valid && host_slot_c;
    host_wr_c   = grant_c && in_range_c;
    issue_c     = !reset && fetching_c && !(host_slot_c && wr_valid);

    wr_ready  = grant_c;
    mem_en    = issue_c || host_wr_c;
    mem_we    = host_wr_c;
    mem_addr  = host_wr_c ? wr_addr : rd_addr;
    mem_wdata = host_wr_c ? wr_data : '0;
  end

  assign lb_data = mem_rdata;

  // Fetch sequencing; a new valid line_start always wins and restarts the fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      fetch_bank <= 1'b0;
      disp_bank  <= 1'b0;
      slot       <= '0;
      underrun   <= 1'b0;
      line_ready <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      line_ready <= 1'b0;
      wr_err     <= grant_c && !in_range_c;

      // The first cycle of a fetch is offered to the host, so host latency stays bounded.
      if (start_ok_c) begin
        slot <= SLOT_HOST;
      end else if (fetching_c) begin
        slot <= (slot == SLOT_HOST) ? '0 : slot + SLOT_W'(1);
      end

      if (start_ok_c) begin
        if (state != ST_IDLE) begin
          underrun <= 1'b1;
        end
        fetch_bank <= !fetch_bank;
        state      <= ST_FETCH_U;
      end else begin
        case (state)
          ST_FETCH_U: begin
            if (issue_c && last_word_c) begin
              state <= ST_FETCH_L;
            end
          end
          ST_FETCH_L: begin
            if (issue_c && last_word_c) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            line_ready <= 1'b1;
            disp_bank  <= fetch_bank;
            state      <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  cstn_fetch_addr_gen #(
    .ADDR_W (ADDR_W),
    .LB_AW  (LB_AW),
    .IDX_W  (8)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .load        (start_ok_c),
    .load_idx    (line_idx),
    .issue       (issue_c),
    .bank        (fetch_bank),
    .rd_addr     (rd_addr),
    .last_word_c (last_word_c),
    .lb_we       (lb_we),
    .lb_bank     (lb_bank),
    .lb_half     (lb_half),
    .lb_addr     (lb_addr)
  );

endmodule
